// File: rtl/ins_issue.sv
// ins_issue: instruction fetch-and-issue sequencer for the single-cycle RISC core.
// Owns the program counter and fetches 24-bit words from a synchronous ROM.
// Each word is issued on func with a one-cycle new_ins pulse. The block then
// waits for pc_enable, and updates the PC sequentially or to a branch target.
// Optional feature macro: FETCH_WDT_EN. When it is defined, a watchdog halts
// the block if pc_enable does not arrive within WDT_CYCLES issue/wait cycles.
module ins_issue #(
    parameter int PC_W       = 8,
    parameter int WDT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [23:0]     imem_data,
    output logic [23:0]     func,
    output logic            new_ins,
    input  logic            pc_enable,
    input  logic            branch,
    output logic            busy,
    output logic            halted,
    output logic            wdt_err,
    output logic [15:0]     retired
);

    localparam logic [3:0] OPC_HALT = 4'hF;

    // The branch target comes from func[PC_W-1:0], so PC_W must fit in the word.
    if (PC_W < 1 || PC_W > 24 || WDT_CYCLES < 1) begin : g_param_check
        $error("ins_issue: PC_W must be 1..24 and WDT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    // The HALT opcode stops fetching. Nothing is issued for it.
    function automatic logic is_halt_op(input logic [3:0] opcode);
        return (opcode == OPC_HALT);
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [PC_W-1:0] pc_r;
    logic [23:0]     func_r;
    logic            new_ins_r;
    logic            busy_r;
    logic            halted_r;
    logic            wdt_err_r;
    logic [15:0]     retired_r;

    logic            done_s;
    logic            issue_s;
    logic            wdt_expire_s;
    logic            wdt_hit_s;
    logic            busy_s;
    logic            halted_s;

`ifdef FETCH_WDT_EN
    localparam int WDT_CNT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

    logic [WDT_CNT_W-1:0] wdt_cnt_r;

    // Watchdog counter. It restarts on each issue and counts the issue/wait
    // cycles that pass without pc_enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt_r <= '0;
        end else if (issue_s) begin
            wdt_cnt_r <= '0;
        end else if ((state_r == ST_ISSUE || state_r == ST_WAIT) && !pc_enable) begin
            wdt_cnt_r <= wdt_cnt_r + WDT_CNT_W'(1);
        end else begin
            wdt_cnt_r <= wdt_cnt_r;
        end
    end

    // This is the last cycle allowed. If pc_enable is also present in this
    // cycle, completion still wins over expiry.
    assign wdt_hit_s = (wdt_cnt_r == WDT_CNT_W'(WDT_CYCLES - 1));
`else
    assign wdt_hit_s = 1'b0;
`endif

    // Next-state logic. It also produces the issue, completion and expiry strobes.
    always_comb begin
        state_s      = state_r;
        done_s       = 1'b0;
        issue_s      = 1'b0;
        wdt_expire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_s = ST_DATA;
            end
            ST_DATA: begin
                if (is_halt_op(imem_data[23:20])) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_ISSUE;
                    issue_s = 1'b1;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (pc_enable) begin
                    state_s = ST_ADDR;
                    done_s  = 1'b1;
                end else if (wdt_hit_s) begin
                    state_s      = ST_HALT;
                    wdt_expire_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Decode the status flags from the next state, so that they can be registered.
    always_comb begin
        busy_s   = 1'b0;
        halted_s = 1'b0;
        case (state_s)
            ST_ADDR, ST_DATA, ST_ISSUE, ST_WAIT: begin
                busy_s = 1'b1;
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                busy_s   = 1'b0;
                halted_s = 1'b0;
            end
        endcase
    end

    // State register and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            busy_r   <= busy_s;
            halted_r <= halted_s;
        end
    end

    // Issue path. func keeps its value until the next issue. new_ins is high
    // only in the cycle that follows DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            func_r    <= 24'h00_0000;
            new_ins_r <= 1'b0;
        end else begin
            new_ins_r <= issue_s;
            if (issue_s) begin
                func_r <= imem_data;
            end else begin
                func_r <= func_r;
            end
        end
    end

    // The PC and the retired count change only on completion. The PC changes
    // only on the edge that enters ADDR, so the ROM address is stable in ADDR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r      <= '0;
            retired_r <= 16'd0;
        end else if (done_s) begin
            pc_r      <= branch ? func_r[PC_W-1:0] : (pc_r + PC_W'(1));
            retired_r <= retired_r + 16'd1;
        end else begin
            pc_r      <= pc_r;
            retired_r <= retired_r;
        end
    end

    // Sticky watchdog error flag. Only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_err_r <= 1'b0;
        end else if (wdt_expire_s) begin
            wdt_err_r <= 1'b1;
        end else begin
            wdt_err_r <= wdt_err_r;
        end
    end

    assign imem_addr = pc_r;
    assign func      = func_r;
    assign new_ins   = new_ins_r;
    assign busy      = busy_r;
    assign halted    = halted_r;
    assign wdt_err   = wdt_err_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_ins_issue.sv
// Testbench for ins_issue.
// Instance u_a uses PC_W=8 and carries the table-driven program and the reset tests.
// Instance u_b uses PC_W=4 and covers PC wrap-around.
// The watchdog cases are compiled only when FETCH_WDT_EN is defined.
module tb_ins_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_start, a_pc_en, a_br;
    logic [7:0]  a_addr;
    logic [23:0] a_rom_q, a_func;
    logic        a_new_ins, a_busy, a_halted, a_wdt;
    logic [15:0] a_ret;

    logic        b_start, b_pc_en, b_br;
    logic [3:0]  b_addr;
    logic [23:0] b_rom_q, b_func;
    logic        b_new_ins, b_busy, b_halted, b_wdt;
    logic [15:0] b_ret;

    ins_issue #(.PC_W(8), .WDT_CYCLES(16)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .imem_addr(a_addr),
        .imem_data(a_rom_q), .func(a_func), .new_ins(a_new_ins),
        .pc_enable(a_pc_en), .branch(a_br), .busy(a_busy),
        .halted(a_halted), .wdt_err(a_wdt), .retired(a_ret)
    );

    ins_issue #(.PC_W(4), .WDT_CYCLES(16)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .imem_addr(b_addr),
        .imem_data(b_rom_q), .func(b_func), .new_ins(b_new_ins),
        .pc_enable(b_pc_en), .branch(b_br), .busy(b_busy),
        .halted(b_halted), .wdt_err(b_wdt), .retired(b_ret)
    );

    logic [23:0] rom_a [256];
    logic [23:0] rom_b [16];

    always @(posedge clk) begin
        a_rom_q <= rom_a[a_addr];
        b_rom_q <= rom_b[b_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int last_mark = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [23:0] word;
        int          k;
        bit          wait_br;
        bit          br;
        logic [7:0]  next_pc;
    } vec_t;

    typedef struct {
        logic [23:0] word;
        logic [7:0]  pc;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   bq[$];
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_a();
        check("rst_addr",    32'(a_addr),    32'd0);
        check("rst_func",    32'(a_func),    32'd0);
        check("rst_new_ins", 32'(a_new_ins), 32'd0);
        check("rst_busy",    32'(a_busy),    32'd0);
        check("rst_halted",  32'(a_halted),  32'd0);
        check("rst_wdt",     32'(a_wdt),     32'd0);
        check("rst_retired", 32'(a_ret),     32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_a();
        check("rst_b_addr", 32'(b_addr), 32'd0);
        check("rst_b_ret",  32'(b_ret),  32'd0);
        a_start = 1'b0; a_pc_en = 1'b0; a_br = 1'b0;
        b_start = 1'b0; b_pc_en = 1'b0; b_br = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic start_a();
        @(negedge clk);
        a_start   = 1'b1;
        last_mark = cyc;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_issue_a(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (a_new_ins === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("issue_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_entry(input vec_t v, input int exp_ret);
        bit   seen;
        exp_t e;
        wait_issue_a(seen);
        if (seen) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: issue at pc %0h with no expectation queued", a_addr);
            end else begin
                e = sb.pop_front();
                check("issue_func", 32'(a_func), 32'(e.word));
                check("issue_addr", 32'(a_addr), 32'(e.pc));
                check("issue_gap",  32'(cyc - last_mark), 32'(e.gap));
            end
            last_mark = cyc;
            for (int j = 0; j < v.k; j++) begin
                a_pc_en = 1'b0;
                a_br    = v.wait_br;
                @(negedge clk);
                check("wait_new_ins", 32'(a_new_ins), 32'd0);
                check("wait_func",    32'(a_func),    32'(v.word));
                check("wait_addr",    32'(a_addr),    32'(v.pc));
            end
            a_pc_en = 1'b1;
            a_br    = v.br;
            @(negedge clk);
            a_pc_en = 1'b0;
            a_br    = 1'b0;
            check("next_addr",  32'(a_addr),    32'(v.next_pc));
            check("retired",    32'(a_ret),     32'(exp_ret));
            check("addr_busy",  32'(a_busy),    32'd1);
            check("addr_newin", 32'(a_new_ins), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit     seen;
        vec_t   r[3];
        exp_t   e;
        int     p;

        rst = 1'b0;
        a_start = 1'b0; a_pc_en = 1'b0; a_br = 1'b0;
        b_start = 1'b0; b_pc_en = 1'b0; b_br = 1'b0;
        for (int i = 0; i < 256; i++) rom_a[i] = 24'hF00000;
        for (int i = 0; i < 16; i++)  rom_b[i] = {8'h12, 12'h000, 4'(i)};

        //           pc      word         k  wait_br br    next_pc
        tbl[0] = '{8'h00, 24'h010005, 0, 1'b0, 1'b0, 8'h01};
        tbl[1] = '{8'h01, 24'h120003, 4, 1'b0, 1'b0, 8'h02};
        tbl[2] = '{8'h02, 24'h600020, 4, 1'b0, 1'b1, 8'h20};
        tbl[3] = '{8'h20, 24'h230005, 2, 1'b1, 1'b0, 8'h21};
        tbl[4] = '{8'h21, 24'h7000FF, 1, 1'b0, 1'b1, 8'hFF};
        tbl[5] = '{8'hFF, 24'h300001, 0, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{8'h00, 24'h010005, 0, 1'b0, 1'b1, 8'h05};
        tbl[7] = '{8'h05, 24'h400009, 2, 1'b1, 1'b1, 8'h09};

        // Reset state.
        do_reset();

        // Table-driven program on u_a. ROM[9] holds HALT.
        for (int i = 0; i < 8; i++) rom_a[tbl[i].pc] = tbl[i].word;
        for (int i = 0; i < 8; i++) begin
            e.word = tbl[i].word;
            e.pc   = tbl[i].pc;
            e.gap  = (i == 0) ? 3 : 3 + tbl[i-1].k;
            sb.push_back(e);
        end
        start_a();
        for (int i = 0; i < 8; i++) run_entry(tbl[i], i + 1);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (a_halted === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("halt_seen",    32'(seen),      32'd1);
        check("halt_busy",    32'(a_busy),    32'd0);
        check("halt_retired", 32'(a_ret),     32'd8);
        check("halt_func",    32'(a_func),    32'h400009);
        check("halt_new_ins", 32'(a_new_ins), 32'd0);
        repeat (3) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        check("halt_sticky", 32'(a_halted), 32'd1);

        // Wrap at PC_W=4. A start pulse in mid-run must be ignored.
        do_reset();
        for (int i = 0; i < 20; i++) bq.push_back(i % 16);
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = 1'b0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (b_new_ins === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("b_issue_seen", 32'(seen), 32'd1);
            p = bq.pop_front();
            check("b_issue_addr", 32'(b_addr), 32'(p));
            check("b_issue_func", 32'(b_func), 32'(rom_b[p]));
            b_pc_en = 1'b1;
            if (i == 7) b_start = 1'b1;
            @(negedge clk);
            b_pc_en = 1'b0;
            b_start = 1'b0;
            check("b_next_addr", 32'(b_addr), 32'((p + 1) % 16));
            check("b_retired",   32'(b_ret),  32'(i + 1));
        end

        // Asynchronous reset while waiting at PC 3, followed by a restart from PC 0.
        do_reset();
        rom_a[3] = 24'h500003;
        r[0] = tbl[0];
        r[1] = '{8'h01, 24'h120003, 0, 1'b0, 1'b0, 8'h02};
        r[2] = '{8'h02, 24'h600020, 0, 1'b0, 1'b0, 8'h03};
        for (int i = 0; i < 3; i++) begin
            e.word = r[i].word;
            e.pc   = r[i].pc;
            e.gap  = 3;
            sb.push_back(e);
        end
        start_a();
        for (int i = 0; i < 3; i++) run_entry(r[i], i + 1);
        wait_issue_a(seen);
        check("pc3_func", 32'(a_func), 32'h500003);
        check("pc3_addr", 32'(a_addr), 32'd3);
`ifndef FETCH_WDT_EN
        repeat (20) @(negedge clk);
        check("nowdt_err",    32'(a_wdt),    32'd0);
        check("nowdt_halted", 32'(a_halted), 32'd0);
        check("nowdt_busy",   32'(a_busy),   32'd1);
`else
        repeat (2) @(negedge clk);
`endif
        #2 rst = 1'b0;
        #1;
        check_reset_a();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        e.word = tbl[0].word;
        e.pc   = 8'h00;
        e.gap  = 3;
        sb.push_back(e);
        start_a();
        run_entry(tbl[0], 1);

`ifdef FETCH_WDT_EN
        // Watchdog expiry when pc_enable is withheld.
        do_reset();
        start_a();
        wait_issue_a(seen);
        repeat (14) @(negedge clk);
        check("wdt_c15_halted", 32'(a_halted), 32'd0);
        @(negedge clk);
        check("wdt_c16_halted", 32'(a_halted), 32'd0);
        @(negedge clk);
        check("wdt_halted",  32'(a_halted), 32'd1);
        check("wdt_err",     32'(a_wdt),    32'd1);
        check("wdt_busy",    32'(a_busy),   32'd0);
        check("wdt_retired", 32'(a_ret),    32'd0);

        // pc_enable in the expiry cycle completes normally.
        do_reset();
        start_a();
        wait_issue_a(seen);
        repeat (15) @(negedge clk);
        a_pc_en = 1'b1;
        @(negedge clk);
        a_pc_en = 1'b0;
        check("wdt_last_addr",    32'(a_addr),   32'd1);
        check("wdt_last_err",     32'(a_wdt),    32'd0);
        check("wdt_last_halted",  32'(a_halted), 32'd0);
        check("wdt_last_retired", 32'(a_ret),    32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ins_issue.md
# ins_issue

Instruction fetch-and-issue sequencer that feeds the control unit of the single-cycle RISC core. It owns the program counter, reads 24-bit instruction words from a synchronous instruction ROM, and presents each word on `func` with a one-cycle `new_ins` pulse. It then waits for the control unit to return `pc_enable` and updates the PC sequentially or to a branch target.

## Interface
- `PC_W`, 8: program counter and instruction-memory address width.
- `WDT_CYCLES`, 16: watchdog limit, in cycles; used only when `FETCH_WDT_EN` is defined.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: begin execution from PC 0; sampled only in IDLE.
- `imem_addr` output PC_W: instruction ROM address; always equals the PC register.
- `imem_data` input 24: ROM read data; valid the cycle after the ROM samples `imem_addr` on a rising edge.
- `func` output 24: issued instruction word. Fields are `[23:20]` opcode, `[19:16]` op1, `[15:0]` data or op2.
- `new_ins` output 1: one-cycle pulse marking a freshly issued `func`.
- `pc_enable` input 1: control unit reports that the current instruction is complete.
- `branch` input 1: qualifies `pc_enable`; selects the branch target.
- `busy` output 1: high in ADDR, DATA, ISSUE and WAIT.
- `halted` output 1: high in HALT.
- `wdt_err` output 1: watchdog expiry flag; sticky until reset.
- `retired` output 16: count of completed instructions.

## Operation
- States: IDLE, ADDR, DATA, ISSUE, WAIT, HALT.
- IDLE: if `start`=1, go to ADDR. Otherwise remain in IDLE.
- ADDR: one cycle with the PC stable. The ROM samples the PC on the exit edge. Next state is DATA.
- DATA: `imem_data` is valid during this cycle. On the exit edge:
  - If `imem_data[23:20]`=4'hF (HALT opcode): go to HALT. `func` and `new_ins` do not change and `retired` does not increment.
  - Otherwise: `func <= imem_data`, `new_ins <= 1`, go to ISSUE.
- ISSUE: `new_ins`=1 for exactly this cycle. `pc_enable` is honoured in this cycle, so a single-cycle instruction can complete here. If it is not seen, go to WAIT.
- WAIT: hold `func` with `new_ins`=0 until `pc_enable`=1.
- Completion (`pc_enable`=1 in ISSUE or WAIT):
  - Next PC is `func[PC_W-1:0]` if `branch`=1, otherwise `pc+1` modulo 2^PC_W. PC 2^PC_W-1 wraps to 0.
  - `retired` increments modulo 2^16.
  - Next state is ADDR.
- `pc_enable` and `branch` are ignored outside ISSUE/WAIT. `branch` without `pc_enable` has no effect.
- `start` is ignored outside IDLE.
- HALT exits only through reset.
- `func` holds its last issued value until the next issue.
- Reset values: state IDLE, PC 0, `func` 24'h0, `new_ins` 0, `busy` 0, `halted` 0, `wdt_err` 0, `retired` 0.
- An asserted `rst` aborts any state immediately; no partial PC or `retired` update survives.

## Timing
- `start` sampled at edge E0 → ADDR in cycle 1 → DATA in cycle 2 → `new_ins` high in cycle 3.
- Instruction period is 3 cycles when `pc_enable` arrives in ISSUE, and 3+k cycles when it arrives in the k-th WAIT cycle.
- `imem_addr` changes only on the edge entering ADDR.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `FETCH_WDT_EN` defined:
  - A counter clears on entry to ISSUE and increments each ISSUE/WAIT cycle without `pc_enable`.
  - When it reaches `WDT_CYCLES`, the block goes to HALT with `wdt_err`=1 and `halted`=1.
  - A `pc_enable` arriving on the expiry cycle has priority: normal completion, no error.
- `FETCH_WDT_EN` undefined: WAIT lasts indefinitely, `wdt_err` is tied to 0, and `WDT_CYCLES` is unused.

## Test plan
- Reset with `start`=0; ROM 0:=24'h010005, 1:=24'hF00000. Release reset, pulse `start`, return `pc_enable` in ISSUE → `new_ins` in cycle 3 with `func`=24'h010005, `imem_addr` 0→1, then `halted`=1 and `retired`=1.
- ROM 0..2 non-HALT words, 3:=HALT; delay `pc_enable` by 4 WAIT cycles each time → `func` is held and `new_ins` stays 0 while waiting, each instruction takes 7 cycles, and the final state is `retired`=3, HALT.
- Word 24'h600020 at PC 5 with `pc_enable`=1 and `branch`=1 → next `imem_addr`=8'h20. Repeat with `branch`=1 but `pc_enable`=0 for 2 cycles → PC stays 5.
- PC_W=4, ROM filled with non-HALT words, `pc_enable` every ISSUE → PC 15 wraps to 0 and `retired` keeps counting; pulsing `start` mid-run has no effect.
- Assert `rst` during WAIT at PC 3 → all outputs return to reset values immediately. On the next `start`, fetch restarts at PC 0.
- With `FETCH_WDT_EN` and `WDT_CYCLES`=16, withhold `pc_enable` → `wdt_err`=1 and `halted`=1 after 16 ISSUE/WAIT cycles. With `pc_enable` on the 16th cycle → normal completion and `wdt_err`=0.
